// File: rtl/window_stage.sv
// K x K sliding-window generator for a raster pixel stream, built from K-1 line buffers
// and a register window. It also flags full windows, outputs the centre pixel and detects overlong lines.
module window_stage #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned K         = 7,
  parameter int unsigned IMG_WIDTH = 640
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  de_in,
  input  logic [DATA_W-1:0]     data_in,
  output logic [K*K*DATA_W-1:0] window_out,
  output logic                  window_valid,
  output logic [DATA_W-1:0]     centre_out,
  output logic                  line_overflow
);

  localparam int unsigned CW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned RW = $clog2(K);
  localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [CW-1:0] ColEnd  = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] ColFull = CW'(K - 1);
  localparam logic [RW-1:0] RowFull = RW'(K - 1);

  logic [CW-1:0]     col_q, col_d, col_eff;
  logic [RW-1:0]     row_q, row_d, row_eff;
  logic              de_prev_q;
  logic              accept, overflow, line_end, valid_d, ovf_d;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] col_vec [K];
  logic [DATA_W-1:0] win_q   [K][K];
  logic [DATA_W-1:0] win_d   [K][K];
  logic [DATA_W-1:0] linebuf [K-1][IMG_WIDTH];

  // A frame_start pixel is treated as column 0, row 0 of the new frame.
  always_comb begin
    col_eff  = frame_start ? '0 : col_q;
    row_eff  = frame_start ? '0 : row_q;
    accept   = de_in && (col_eff < ColEnd);
    overflow = de_in && (col_eff == ColEnd);
    line_end = de_prev_q && !de_in && !frame_start;
    valid_d  = accept && (col_eff >= ColFull) && (row_eff >= RowFull);
    addr     = col_eff[AW-1:0];
  end

  // Bottom of the column is the live pixel; rows above come from progressively older lines.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      col_vec[r] = '0;
    end
    col_vec[K-1] = data_in;
    for (int unsigned i = 1; i < K; i++) begin
      col_vec[K-1-i] = linebuf[i-1][addr];
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = col_vec[r];
      end
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ovf_d = line_overflow;
    if (frame_start) begin
      col_d = de_in ? CW'(1) : '0;
      row_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (line_end) begin
        col_d = '0;
        row_d = (row_q == RowFull) ? row_q : row_q + RW'(1);
      end else if (accept) begin
        col_d = col_q + CW'(1);
      end
      if (overflow) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q         <= '0;
      row_q         <= '0;
      de_prev_q     <= 1'b0;
      window_valid  <= 1'b0;
      line_overflow <= 1'b0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      de_prev_q     <= de_in;
      window_valid  <= valid_d;
      line_overflow <= ovf_d;
      win_q         <= win_d;
    end
  end

  // Line buffer contents are never cleared; validity gating makes stale entries harmless.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      linebuf[0][addr] <= data_in;
      for (int unsigned i = 1; i < K - 1; i++) begin
        linebuf[i][addr] <= linebuf[i-1][addr];
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        window_out[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

  assign centre_out = win_q[K/2][K/2];

endmodule
